// File: rtl/sequenciador_ula.sv
// Multi-cycle execute controller wrapped around an external 8-bit ALU, with a 4-entry register bank.
// Optional retired-instruction counter enabled by defining CONTADOR_INSTR_EN.
module sequenciador_ula #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valida,
  input  logic [7:0]         instr,
  output logic               pronto,
  input  logic               carga_valida,
  input  logic [1:0]         carga_end,
  input  logic [LARGURA-1:0] carga_dado,
  output logic [LARGURA-1:0] entrada1,
  output logic [LARGURA-1:0] entrada2,
  output logic [2:0]         sinal_ula,
  input  logic [LARGURA-1:0] saida_ula,
  input  logic               zero,
  output logic [LARGURA-1:0] resultado,
  output logic               concluido,
  output logic               desvio
`ifdef CONTADOR_INSTR_EN
  ,
  output logic [15:0]        instr_retiradas
`endif
);

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    LE_OPERANDOS = 2'd1,
    EXECUTA      = 2'd2,
    ESCRITA      = 2'd3
  } estado_t;

  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_BEQ = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  estado_t            r_estado;
  logic [LARGURA-1:0] r_banco [4];
  logic [2:0]         r_op;
  logic [1:0]         r_rd;
  logic [1:0]         r_rt;
  logic               r_flag;
  logic [LARGURA-1:0] r_entrada1;
  logic [LARGURA-1:0] r_entrada2;
  logic [2:0]         r_sinal_ula;
  logic [LARGURA-1:0] r_resultado;
  logic               r_concluido;
  logic               r_desvio;

  logic [2:0]         w_sel;
  logic [LARGURA-1:0] w_oper_a;
  logic               w_escreve;

  // mov routes reg[rt] to both operands and ORs them, so the ALU passes it through
  always_comb begin
    w_sel = r_op;
    unique case (r_op)
      OP_BEQ:  w_sel = OP_SUB;
      OP_MOV:  w_sel = 3'b001;
      OP_NOP:  w_sel = 3'b000;
      default: w_sel = r_op;
    endcase
  end

  assign w_oper_a  = (r_op == OP_MOV) ? r_banco[r_rt] : r_banco[r_rd];
  assign w_escreve = (r_op <= OP_SLT) || (r_op == OP_MOV);

  assign pronto    = (r_estado == OCIOSO) && !carga_valida;
  assign entrada1  = r_entrada1;
  assign entrada2  = r_entrada2;
  assign sinal_ula = r_sinal_ula;
  assign resultado = r_resultado;
  assign concluido = r_concluido;
  assign desvio    = r_desvio;

`ifdef CONTADOR_INSTR_EN
  logic [15:0] r_retiradas;
  assign instr_retiradas = r_retiradas;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= OCIOSO;
      for (int i = 0; i < 4; i++) begin
        r_banco[i] <= '0;
      end
      r_op        <= '0;
      r_rd        <= '0;
      r_rt        <= '0;
      r_flag      <= 1'b0;
      r_entrada1  <= '0;
      r_entrada2  <= '0;
      r_sinal_ula <= 3'b000;
      r_resultado <= '0;
      r_concluido <= 1'b0;
      r_desvio    <= 1'b0;
`ifdef CONTADOR_INSTR_EN
      r_retiradas <= '0;
`endif
    end else begin
      r_concluido <= 1'b0;
      r_desvio    <= 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          // a preload wins the cycle; the pending instruction stays on the bus
          if (carga_valida) begin
            r_banco[carga_end] <= carga_dado;
          end else if (instr_valida) begin
            r_op     <= instr[7:5];
            r_rd     <= instr[3:2];
            r_rt     <= instr[1:0];
            r_estado <= LE_OPERANDOS;
          end
        end
        LE_OPERANDOS: begin
          r_entrada1  <= w_oper_a;
          r_entrada2  <= r_banco[r_rt];
          r_sinal_ula <= w_sel;
          r_estado    <= EXECUTA;
        end
        EXECUTA: begin
          r_resultado <= saida_ula;
          r_flag      <= zero;
          r_estado    <= ESCRITA;
        end
        ESCRITA: begin
          if (w_escreve) begin
            r_banco[r_rd] <= r_resultado;
          end
          r_concluido <= 1'b1;
          r_desvio    <= (r_op == OP_BEQ) && r_flag;
`ifdef CONTADOR_INSTR_EN
          r_retiradas <= r_retiradas + 16'd1;
`endif
          r_estado    <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_ula.sv
// Directed bench for sequenciador_ula: models the ALU, issues instructions and checks retire behaviour.
module tb_sequenciador_ula;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valida = 1'b0;
  logic [7:0]  instr = 8'h00;
  logic        pronto;
  logic        carga_valida = 1'b0;
  logic [1:0]  carga_end = 2'd0;
  logic [7:0]  carga_dado = 8'h00;
  logic [7:0]  entrada1;
  logic [7:0]  entrada2;
  logic [2:0]  sinal_ula;
  logic [7:0]  saida_ula;
  logic        zero;
  logic [7:0]  resultado;
  logic        concluido;
  logic        desvio;
`ifdef CONTADOR_INSTR_EN
  logic [15:0] instr_retiradas;
`endif

  int n_checks = 0;
  int n_erros  = 0;
  int n_ret    = 0;

  always #5 clock = ~clock;

  sequenciador_ula #(.LARGURA(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr_valida (instr_valida),
    .instr        (instr),
    .pronto       (pronto),
    .carga_valida (carga_valida),
    .carga_end    (carga_end),
    .carga_dado   (carga_dado),
    .entrada1     (entrada1),
    .entrada2     (entrada2),
    .sinal_ula    (sinal_ula),
    .saida_ula    (saida_ula),
    .zero         (zero),
    .resultado    (resultado),
    .concluido    (concluido),
    .desvio       (desvio)
`ifdef CONTADOR_INSTR_EN
    ,
    .instr_retiradas (instr_retiradas)
`endif
  );

  // Reference ALU sitting outside the controller
  always_comb begin
    case (sinal_ula)
      3'b000:  saida_ula = entrada1 & entrada2;
      3'b001:  saida_ula = entrada1 | entrada2;
      3'b010:  saida_ula = entrada1 + entrada2;
      3'b011:  saida_ula = entrada1 - entrada2;
      3'b100:  saida_ula = (entrada1 < entrada2) ? 8'd1 : 8'd0;
      default: saida_ula = 8'd0;
    endcase
    zero = (saida_ula == 8'd0);
  end

  task automatic verifica(input string tag, input logic [15:0] obs, input logic [15:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  task automatic carga(input logic [1:0] e, input logic [7:0] d);
    @(negedge clock);
    carga_valida = 1'b1;
    carga_end    = e;
    carga_dado   = d;
    @(negedge clock);
    carga_valida = 1'b0;
  endtask

  // Entered at the negedge right after the accept edge; keeps poking instr_valida while busy
  task automatic aguarda(input logic [7:0] cod, output int lat, output logic [7:0] res,
                         output logic desv);
    lat  = 0;
    res  = 8'h00;
    desv = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      instr_valida = (n <= 2);
      instr        = 8'hE5;
      @(negedge clock);
      if (concluido) begin
        lat  = n;
        res  = resultado;
        desv = desvio;
        break;
      end
    end
    instr_valida = 1'b0;
    if (lat != 0) n_ret++;
    $display("instr=%h latencia=%0d resultado=%h desvio=%b", cod, lat, res, desv);
    verifica("latencia", 16'(lat), 16'd3);
    @(negedge clock);
    verifica("pulso_unico", {15'd0, concluido}, 16'd0);
    verifica("desvio_unico", {15'd0, desvio}, 16'd0);
    verifica("pronto_pos", {15'd0, pronto}, 16'd1);
  endtask

  task automatic executa(input logic [7:0] cod, output int lat, output logic [7:0] res,
                         output logic desv);
    @(negedge clock);
    instr_valida = 1'b1;
    instr        = cod;
    @(negedge clock);
    instr_valida = 1'b0;
    aguarda(cod, lat, res, desv);
  endtask

  task automatic le_reg(input logic [1:0] r, output logic [7:0] v);
    int         lat;
    logic [7:0] res;
    logic       desv;
    executa({3'b111, 1'b0, r, r}, lat, res, desv);
    v = entrada1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observado=timeout esperado=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] tab_cod [6] = '{8'h01, 8'h21, 8'h61, 8'h81, 8'h84, 8'h4A};
  logic [7:0] tab_res [6] = '{8'h0A, 8'h5F, 8'h4B, 8'h00, 8'h01, 8'h02};
  logic [2:0] tab_sel [6] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b100, 3'b010};

  initial begin
    int         lat;
    logic [7:0] res;
    logic       desv;
    logic [7:0] v;
    logic [7:0] c;
    logic       viu;

    repeat (2) @(negedge clock);
    verifica("rst_pronto", {15'd0, pronto}, 16'd1);
    verifica("rst_entrada1", {8'd0, entrada1}, 16'd0);
    verifica("rst_entrada2", {8'd0, entrada2}, 16'd0);
    verifica("rst_sinal", {13'd0, sinal_ula}, 16'd0);
    verifica("rst_resultado", {8'd0, resultado}, 16'd0);
    verifica("rst_concluido", {15'd0, concluido}, 16'd0);
    verifica("rst_desvio", {15'd0, desvio}, 16'd0);
`ifdef CONTADOR_INSTR_EN
    verifica("rst_contador", instr_retiradas, 16'd0);
`endif
    reset_n = 1'b1;

    // add r1 = r1 + r2
    carga(2'd1, 8'h05);
    carga(2'd2, 8'h03);
    executa(8'h46, lat, res, desv);
    verifica("add_sinal", {13'd0, sinal_ula}, 16'd2);
    verifica("add_resultado", {8'd0, res}, 16'h08);
    verifica("add_desvio", {15'd0, desv}, 16'd0);
    le_reg(2'd1, v);
    verifica("add_r1", {8'd0, v}, 16'h08);

    // add with wrap
    carga(2'd0, 8'hFF);
    carga(2'd3, 8'h02);
    executa(8'h43, lat, res, desv);
    verifica("wrap_resultado", {8'd0, res}, 16'h01);
    verifica("wrap_desvio", {15'd0, desv}, 16'd0);
    le_reg(2'd0, v);
    verifica("wrap_r0", {8'd0, v}, 16'h01);

    // beq taken
    carga(2'd2, 8'h07);
    carga(2'd3, 8'h07);
    executa(8'hAB, lat, res, desv);
    verifica("beq_sinal", {13'd0, sinal_ula}, 16'd3);
    verifica("beq_desvio", {15'd0, desv}, 16'd1);
    le_reg(2'd2, v);
    verifica("beq_r2", {8'd0, v}, 16'h07);

    // beq not taken
    carga(2'd3, 8'h06);
    executa(8'hAB, lat, res, desv);
    verifica("bne_desvio", {15'd0, desv}, 16'd0);
    verifica("bne_resultado", {8'd0, res}, 16'h01);
    le_reg(2'd2, v);
    verifica("bne_r2", {8'd0, v}, 16'h07);

    // preload and mov r1 <- r0 in the same cycle: preload first, instruction held
    @(negedge clock);
    carga_valida = 1'b1;
    carga_end    = 2'd0;
    carga_dado   = 8'h11;
    instr_valida = 1'b1;
    instr        = 8'hC4;
    #1;
    verifica("col_pronto0", {15'd0, pronto}, 16'd0);
    @(negedge clock);
    carga_valida = 1'b0;
    #1;
    verifica("col_pronto1", {15'd0, pronto}, 16'd1);
    @(negedge clock);
    instr_valida = 1'b0;
    aguarda(8'hC4, lat, res, desv);
    verifica("mov_resultado", {8'd0, res}, 16'h11);
    verifica("mov_sinal", {13'd0, sinal_ula}, 16'd1);
    verifica("mov_entrada1", {8'd0, entrada1}, 16'h11);
    verifica("mov_entrada2", {8'd0, entrada2}, 16'h11);
    le_reg(2'd1, v);
    verifica("mov_r1", {8'd0, v}, 16'h11);

    // remaining opcodes and rd==rt
    for (int k = 0; k < 6; k++) begin
      carga(2'd0, 8'h5A);
      carga(2'd1, 8'h0F);
      carga(2'd2, 8'h81);
      c = tab_cod[k];
      executa(c, lat, res, desv);
      verifica("tab_resultado", {8'd0, res}, {8'd0, tab_res[k]});
      verifica("tab_sinal", {13'd0, sinal_ula}, {13'd0, tab_sel[k]});
      le_reg(c[3:2], v);
      verifica("tab_escrita", {8'd0, v}, {8'd0, tab_res[k]});
    end

`ifdef CONTADOR_INSTR_EN
    verifica("contador", instr_retiradas, 16'(n_ret));
`endif

    // sub aborted by reset during EXECUTA
    carga(2'd0, 8'h09);
    carga(2'd1, 8'h04);
    @(negedge clock);
    instr_valida = 1'b1;
    instr        = 8'h61;
    @(negedge clock);
    instr_valida = 1'b0;
    @(negedge clock);
    verifica("sub_sinal", {13'd0, sinal_ula}, 16'd3);
    verifica("sub_entrada1", {8'd0, entrada1}, 16'h09);
    #2;
    reset_n = 1'b0;
    #1;
    verifica("abt_pronto", {15'd0, pronto}, 16'd1);
    verifica("abt_entrada1", {8'd0, entrada1}, 16'd0);
    verifica("abt_sinal", {13'd0, sinal_ula}, 16'd0);
    verifica("abt_resultado", {8'd0, resultado}, 16'd0);
`ifdef CONTADOR_INSTR_EN
    verifica("abt_contador", instr_retiradas, 16'd0);
`endif
    viu = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (concluido) viu = 1'b1;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (concluido) viu = 1'b1;
    end
    verifica("abt_sem_concluido", {15'd0, viu}, 16'd0);
    verifica("abt_pronto_pos", {15'd0, pronto}, 16'd1);
    le_reg(2'd0, v);
    verifica("abt_r0", {8'd0, v}, 16'd0);
    le_reg(2'd1, v);
    verifica("abt_r1", {8'd0, v}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_ula.md
Name: sequenciador_ula

Overview:
- Multi-cycle execute controller placed directly around the 8-bit ALU.
- Accepts one instruction at a time through a valid/ready handshake and holds a 4-entry register bank.
- Drives the ALU operands and `sinal_ula`, then captures `saida_ula` and `zero`.
- Writes the result back, or raises a branch pulse for branch-if-equal.

Parameters:
- LARGURA, 8, data width of registers, ALU operands and result.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- instr_valida  in  1  instruction present on `instr`.
- instr  in  8  [7:5] opcode, [4] ignored, [3:2] rd (also first source), [1:0] rt.
- pronto  out  1  ready to accept an instruction (combinational).
- carga_valida  in  1  external register preload strobe.
- carga_end  in  2  preload register address.
- carga_dado  in  LARGURA  preload data.
- entrada1  out  LARGURA  ALU operand A (reg[rd]).
- entrada2  out  LARGURA  ALU operand B (reg[rt]).
- sinal_ula  out  3  ALU operation select.
- saida_ula  in  LARGURA  ALU result.
- zero  in  1  ALU zero flag.
- resultado  out  LARGURA  last captured ALU result.
- concluido  out  1  one-cycle pulse when an instruction retires.
- desvio  out  1  one-cycle pulse, coincident with `concluido`, for a taken branch.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=OCIOSO; reg[0..3]=0.
  - entrada1/entrada2/resultado=0; sinal_ula=3'b000.
  - concluido=0, desvio=0; latched instruction cleared.
- Reset asserted mid-instruction aborts it: no write, no `concluido`.
- Opcodes:
  - 000 and, 001 or, 010 add, 011 sub, 100 slt: write reg[rd].
  - 101 beq: sinal_ula=011; no write; desvio=1 if zero=1.
  - 110 mov: sinal_ula=001 with both operands reg[rt], so reg[rd]<=reg[rt].
  - 111 nop: sinal_ula=000; no write.
- `pronto` = (state==OCIOSO) && !carga_valida.
- Instruction is accepted on the rising edge with instr_valida && pronto; `instr` is latched.
- Preload:
  - Performed on the rising edge when state==OCIOSO && carga_valida: reg[carga_end]<=carga_dado.
  - Preload has priority over an instruction in the same cycle; that instruction is not accepted and must be held.
  - Preload outside OCIOSO is ignored.
- FSM, one cycle per state, fixed latency of 3 cycles from accept to `concluido`:
  - OCIOSO -> LE_OPERANDOS on accept; otherwise stay.
  - LE_OPERANDOS: register entrada1, entrada2 and sinal_ula from reg bank and latched opcode -> EXECUTA.
  - EXECUTA: ALU settles combinationally; on exit capture resultado<=saida_ula and flag<=zero -> ESCRITA.
  - ESCRITA:
    - Write reg[rd]<=resultado for opcodes 000-100 and 110.
    - concluido=1; desvio=flag for opcode 101, else 0.
    - -> OCIOSO.
- `entrada1`, `entrada2` and `sinal_ula` hold their values after retire until the next LE_OPERANDOS.
- Arithmetic wraps modulo 2^LARGURA; the ALU provides this, and the block adds no widening.
- rd==rt is legal; both operands read the same register.
- Throughput: at most one instruction per 4 cycles. `pronto` is low in LE_OPERANDOS, EXECUTA and ESCRITA; it returns high in the cycle after ESCRITA.
- `instr_valida` while not `pronto` has no effect.

Optional Feature:
- CONTADOR_INSTR_EN defined:
  - Adds output port `instr_retiradas` (16 bits), reset to 0.
  - Increments by 1 on every `concluido` cycle; wraps 16'hFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Preload r1=8'h05, r2=8'h03; issue add rd=1, rt=2 (instr 8'h46).
  - Expected: sinal_ula=010; concluido exactly 3 cycles after accept; r1=8'h08; resultado=8'h08.
- Preload r0=8'hFF, r3=8'h02; issue add rd=0, rt=3.
  - Expected: r0=8'h01 (wrap); desvio=0.
- Preload r2=8'h07, r3=8'h07; issue beq rd=2, rt=3 (instr 8'hAB).
  - Expected: desvio=1 with concluido; r2 unchanged.
- Repeat the beq with r3=8'h06.
  - Expected: desvio=0.
- Assert carga_valida and instr_valida together in OCIOSO.
  - Expected: preload written, pronto=0 that cycle, instruction accepted on the next cycle.
- Issue sub, then pull reset_n low during EXECUTA.
  - Expected: immediately state OCIOSO, all regs 0, no concluido pulse, pronto=1 after release.
  - With CONTADOR_INSTR_EN defined, `instr_retiradas`=0.
